sbox_ecc_pipe: RTL and testbench
================================

Name: sbox_ecc_pipe

Overview:
- Multi-lane, pipelined AES SubBytes engine with concurrent error detection and single-error correction.
- Each lane forms a 12-bit codeword {sbox(x), w[3:0]} using the team's existing 4-bit Hamming check matrix, computes its syndrome, and corrects single-bit errors.
- Supports test-time fault injection, valid/ready flow control and error statistics.
- Replaces the flat combinational SubBytes/predictor/checker trio inside the round datapath.

Parameters:
- LANES, 4, number of independent byte lanes (1..16); lane k uses bits [8k+7:8k].
- CORRECT, 1, 1 = correct single-bit errors; 0 = detect only, data passed raw.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  8*LANES  bytes to substitute.
- inj_mask  in  12*LANES  XOR mask applied to each lane's stage-1 codeword, sampled with the beat; lane k uses [12k+11:12k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  8*LANES  substituted, corrected bytes.
- out_corr  out  LANES  per lane: a single error was corrected (CORRECT=1) or detected (CORRECT=0).
- out_uncorr  out  LANES  per lane: syndrome is 5, 9 or A (uncorrectable).
- clr_stats  in  1  synchronous clear of counters and sticky flag.
- corr_cnt  out  CNT_W  beats with any out_corr bit set.
- uncorr_cnt  out  CNT_W  beats with any out_uncorr bit set.
- err_fatal  out  1  sticky; set by any uncorrectable beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0, err_fatal=0, both stage valids=0. in_ready=1 one cycle after deassertion.
- Check bits, per lane, with s=sbox(x):
  - w3 = s7^s6^s4^s3^s2
  - w2 = s7^s6^s5^s4^s2^s0
  - w1 = s7^s6^s5^s3^s1^s0
  - w0 = s7^s5^s4^s3^s1
- Codeword c[11:4]=s, c[3:0]=w.
- Stage 1 registers (c ^ inj lane mask) per lane, plus v1.
- Stage 2 syndrome on c:
  - S0 = c11^c10^c8^c7^c6^c3
  - S1 = c11^c10^c9^c8^c6^c4^c2
  - S2 = c11^c10^c9^c7^c5^c4^c1
  - S3 = c11^c9^c8^c7^c5^c0
  - S = {S3,S2,S1,S0}.
- Syndrome decode to the flipped bit:
  - F→c11, 7→c10, E→c9, B→c8, D→c7, 3→c6, C→c5, 6→c4, 1→c3, 2→c2, 4→c1, 8→c0.
  - 5, 9, A → uncorrectable.
  - 0 → clean.
- CORRECT=1: flip the indicated bit, out_data lane = corrected c[11:4]; a check-bit-only fix still sets out_corr.
- CORRECT=0: out_data lane = raw c[11:4]; nonzero decodable syndrome sets out_corr.
- Uncorrectable: data is passed raw, out_corr=0, out_uncorr=1.
- Double errors aliasing to a valid column are miscorrected; this is accepted SEC behaviour, not flagged.
- Latency: exactly 2 cycles from accepted beat to out_valid with no stall.
- Flow control: adv = !out_valid | out_ready; in_ready = adv. All stages shift on adv, otherwise hold. Bubbles propagate as valid=0.
- Throughput is 1 beat/cycle with out_ready held high. Outputs are stable while out_valid & !out_ready.
- Statistics update only on output handshake (out_valid & out_ready):
  - corr_cnt += |out_corr, uncorr_cnt += |out_uncorr, each saturating at all-ones (no wrap).
  - err_fatal set if |out_uncorr.
- clr_stats clears corr_cnt, uncorr_cnt and err_fatal on the next edge. It wins over a simultaneous increment or set (result 0). It does not affect the datapath.
- rst_n asserted mid-stream: in-flight beats are discarded, no partial output.

Test Plan:
- LANES=4, beat in_data=0xFF_53_01_00, inj_mask=0 -> 2 cycles later out_data=0x16_ED_7C_63, out_corr=0, out_uncorr=0, counters unchanged.
- Lane 0 in=0x00 (codeword 0x63C), inj lane0=0x010 (c4) -> S=6, out_data lane0=0x63, out_corr=4'b0001, corr_cnt=1.
- Lane 0 in=0x00, inj lane0=0x081 (c7,c0) -> S=5, out_data lane0=0x6B (raw), out_uncorr=4'b0001, uncorr_cnt=1, err_fatal=1. Then clr_stats pulse -> counters 0, err_fatal=0.
- 8 back-to-back beats with out_ready low for cycles 3-5 -> in_ready low during the stall, no beat lost or duplicated, output order preserved, outputs held stable while stalled.
- CNT_W=2, five consecutive corrected beats -> corr_cnt saturates at 3. clr_stats asserted on the same edge as an increment -> 0.
- Reset asserted with two beats in flight -> out_valid=0 immediately and all counters 0. A new beat after release emerges with 2-cycle latency.

Source files
------------

// File: rtl/sbox_ecc_pipe.sv
// Multi-lane pipelined AES SubBytes with Hamming(12,8) check bits, syndrome
// decode and single-error correction, valid/ready flow control and error stats.
module sbox_ecc_pipe #(
  parameter int LANES   = 4,
  parameter bit CORRECT = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [12*LANES-1:0]   inj_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANES-1:0]    out_data,
  output logic [LANES-1:0]      out_corr,
  output logic [LANES-1:0]      out_uncorr,
  input  logic                  clr_stats,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      uncorr_cnt,
  output logic                  err_fatal
);

  typedef struct packed {
    logic [11:0] flip;
    logic        corr;
    logic        uncorr;
  } dec_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [3:0] check_bits(input logic [7:0] s);
    logic [3:0] w;
    w[3] = s[7] ^ s[6] ^ s[4] ^ s[3] ^ s[2];
    w[2] = s[7] ^ s[6] ^ s[5] ^ s[4] ^ s[2] ^ s[0];
    w[1] = s[7] ^ s[6] ^ s[5] ^ s[3] ^ s[1] ^ s[0];
    w[0] = s[7] ^ s[5] ^ s[4] ^ s[3] ^ s[1];
    return w;
  endfunction

  function automatic logic [3:0] syndrome(input logic [11:0] c);
    logic [3:0] s;
    s[0] = c[11] ^ c[10] ^ c[8] ^ c[7] ^ c[6] ^ c[3];
    s[1] = c[11] ^ c[10] ^ c[9] ^ c[8] ^ c[6] ^ c[4] ^ c[2];
    s[2] = c[11] ^ c[10] ^ c[9] ^ c[7] ^ c[5] ^ c[4] ^ c[1];
    s[3] = c[11] ^ c[9] ^ c[8] ^ c[7] ^ c[5] ^ c[0];
    return s;
  endfunction

  // Each nonzero syndrome equal to a column of the check matrix names one bit;
  // the three unused patterns can only come from multi-bit errors.
  function automatic dec_t decode(input logic [3:0] syn);
    dec_t d;
    d = '0;
    case (syn)
      4'h0: d.flip = 12'h000;
      4'hf: d.flip = 12'h800;
      4'h7: d.flip = 12'h400;
      4'he: d.flip = 12'h200;
      4'hb: d.flip = 12'h100;
      4'hd: d.flip = 12'h080;
      4'h3: d.flip = 12'h040;
      4'hc: d.flip = 12'h020;
      4'h6: d.flip = 12'h010;
      4'h1: d.flip = 12'h008;
      4'h2: d.flip = 12'h004;
      4'h4: d.flip = 12'h002;
      4'h8: d.flip = 12'h001;
      default: d.uncorr = 1'b1;
    endcase
    d.corr = |d.flip;
    return d;
  endfunction

  logic                        adv;
  logic                        rdy_q;
  logic                        v1;
  logic [LANES-1:0][11:0]      enc;
  logic [LANES-1:0][11:0]      c1;
  logic [8*LANES-1:0]          dec_data;
  logic [LANES-1:0]            dec_corr;
  logic [LANES-1:0]            dec_uncorr;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rdy_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]  s;
    dec_t        d;
    logic [11:0] cfix;

    assign s      = sbox(in_data[8*k +: 8]);
    assign enc[k] = {s, check_bits(s)} ^ inj_mask[12*k +: 12];
    assign d      = decode(syndrome(c1[k]));
    assign cfix   = CORRECT ? (c1[k] ^ d.flip) : c1[k];

    assign dec_data[8*k +: 8] = cfix[11:4];
    assign dec_corr[k]        = v1 && d.corr;
    assign dec_uncorr[k]      = v1 && d.uncorr;
  end

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the same pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      v1    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) v1 <= in_valid && in_ready;
    end
  end

  // NOTE: stage-1 payload has no reset; v1 qualifies it, so reset only has to
  // clear the valid bits and keeps the reset tree off the wide datapath.
  always_ff @(posedge clk) begin
    if (adv) c1 <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_corr   <= '0;
      out_uncorr <= '0;
    end else if (adv) begin
      out_valid  <= v1;
      out_data   <= dec_data;
      out_corr   <= dec_corr;
      out_uncorr <= dec_uncorr;
    end
  end

  // Statistics advance only on an output handshake; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      err_fatal  <= 1'b0;
    end else if (clr_stats) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      err_fatal  <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (|out_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (|out_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      if (|out_uncorr)                       err_fatal  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sbox_ecc_pipe.sv
// Self-checking bench for sbox_ecc_pipe: directed vector table, stall, saturation
// and reset sequences, plus randomized traffic against a scoreboard model.
module tb_sbox_ecc_pipe;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic clr_stats = 1'b0;
  logic [31:0] in_data = '0;
  logic [47:0] inj_mask = '0;

  logic        in_ready, out_valid, err_fatal;
  logic [31:0] out_data;
  logic [3:0]  out_corr, out_uncorr;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        s_in_ready, s_out_valid, s_err_fatal;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_corr, s_out_uncorr;
  logic [1:0]  s_corr_cnt, s_uncorr_cnt;

  sbox_ecc_pipe #(.LANES(LANES), .CORRECT(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_mask(inj_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
    .out_uncorr(out_uncorr), .clr_stats(clr_stats), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt), .err_fatal(err_fatal));

  // Detect-only variant with narrow counters, fed the same stimulus.
  sbox_ecc_pipe #(.LANES(LANES), .CORRECT(1'b0), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .inj_mask(inj_mask), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_corr(s_out_corr),
    .out_uncorr(s_out_uncorr), .clr_stats(clr_stats), .corr_cnt(s_corr_cnt),
    .uncorr_cnt(s_uncorr_cnt), .err_fatal(s_err_fatal));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Check-matrix column of codeword bit i (c0..c11), as {S3,S2,S1,S0}.
  localparam logic [3:0] H [12] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h6, 4'hc,
                                    4'h3, 4'hd, 4'hb, 4'he, 4'h7, 4'hf};
  logic [7:0] sb [256];

  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p ^= a << i;
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p ^= 'h11b << (i - 8);
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input int x);
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] cst;
    b = 8'h00;
    for (int y = 1; y < 256; y++) if (x != 0 && gmul(x, y) == 1) b = 8'(y);
    cst = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ cst[i];
    return s;
  endfunction

  // Returns {data[7:0], corr, uncorr} for one lane.
  function automatic logic [9:0] ref_lane(input logic [7:0] x, input logic [11:0] inj,
                                          input bit correct);
    logic [3:0]  d;
    logic [3:0]  syn;
    logic [11:0] c;
    logic        corr;
    logic        unc;
    d = '0;
    for (int i = 0; i < 8; i++) if (sb[x][i]) d ^= H[i+4];
    c = {sb[x], d[0], d[1], d[2], d[3]} ^ inj;
    syn = '0;
    for (int i = 0; i < 12; i++) if (c[i]) syn ^= H[i];
    corr = 1'b0;
    unc  = (syn != 4'h0);
    for (int i = 0; i < 12; i++)
      if (syn != 4'h0 && H[i] == syn) begin
        corr = 1'b1;
        unc  = 1'b0;
        if (correct) c[i] = ~c[i];
      end
    return {c[11:4], corr, unc};
  endfunction

  typedef struct {
    logic [31:0] dm; logic [3:0] cm; logic [3:0] um;
    logic [31:0] ds; logic [3:0] cs; logic [3:0] us;
  } beat_t;

  function automatic beat_t model(input logic [31:0] d, input logic [47:0] inj);
    beat_t b;
    logic [9:0] r;
    for (int k = 0; k < LANES; k++) begin
      r = ref_lane(d[8*k +: 8], inj[12*k +: 12], 1'b1);
      b.dm[8*k +: 8] = r[9:2]; b.cm[k] = r[1]; b.um[k] = r[0];
      r = ref_lane(d[8*k +: 8], inj[12*k +: 12], 1'b0);
      b.ds[8*k +: 8] = r[9:2]; b.cs[k] = r[1]; b.us[k] = r[0];
    end
    return b;
  endfunction

  function automatic logic [47:0] rand_inj();
    logic [47:0] m;
    logic [11:0] l;
    int r;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      r = $urandom_range(0, 3);
      l = '0;
      if (r == 1) l[$urandom_range(0, 11)] = 1'b1;
      else if (r == 2) begin
        l[$urandom_range(0, 11)] = 1'b1;
        l[$urandom_range(0, 11)] ^= 1'b1;
      end
      m[12*k +: 12] = l;
    end
    return m;
  endfunction

  // ---------------- scoreboard monitor ----------------
  beat_t q[$];
  beat_t h;
  int    received = 0;
  logic [15:0] mc = '0, mu = '0;
  logic [1:0]  sc = '0, su = '0;
  logic        mf = 1'b0, sf = 1'b0;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      q.delete();
      mc = '0; mu = '0; mf = 1'b0; sc = '0; su = '0; sf = 1'b0;
    end else begin
      check("corr_cnt", 64'(corr_cnt), 64'(mc));
      check("uncorr_cnt", 64'(uncorr_cnt), 64'(mu));
      check("err_fatal", 64'(err_fatal), 64'(mf));
      check("s_corr_cnt", 64'(s_corr_cnt), 64'(sc));
      check("s_uncorr_cnt", 64'(s_uncorr_cnt), 64'(su));
      check("s_err_fatal", 64'(s_err_fatal), 64'(sf));
      if (q.size() == 0) begin
        check("idle_valid", 64'(out_valid), 64'(0));
        check("s_idle_valid", 64'(s_out_valid), 64'(0));
      end else begin
        h = q[0];
        if (out_valid) begin
          check("out_data", 64'(out_data), 64'(h.dm));
          check("out_corr", 64'(out_corr), 64'(h.cm));
          check("out_uncorr", 64'(out_uncorr), 64'(h.um));
        end
        if (s_out_valid) begin
          check("s_out_data", 64'(s_out_data), 64'(h.ds));
          check("s_out_corr", 64'(s_out_corr), 64'(h.cs));
          check("s_out_uncorr", 64'(s_out_uncorr), 64'(h.us));
        end
      end
      if (clr_stats) begin
        mc = '0; mu = '0; mf = 1'b0; sc = '0; su = '0; sf = 1'b0;
      end else if (out_valid && out_ready && q.size() != 0) begin
        if (|h.cm && mc != 16'hffff) mc++;
        if (|h.um && mu != 16'hffff) mu++;
        if (|h.um) mf = 1'b1;
        if (|h.cs && sc != 2'd3) sc++;
        if (|h.us && su != 2'd3) su++;
        if (|h.us) sf = 1'b1;
      end
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        received++;
      end
      if (in_valid && in_ready) q.push_back(model(in_data, inj_mask));
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(q.size()), 64'(0));
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] d; logic [47:0] inj;
    logic [31:0] ed; logic [3:0] ec; logic [3:0] eu;
  } vec_t;
  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int rx0;
    for (int x = 0; x < 256; x++) sb[x] = ref_sbox(x);

    vt[0] = '{32'hff530100, 48'h0,             32'h16ed7c63, 4'h0, 4'h0};
    vt[1] = '{32'h00000000, 48'h010,           32'h63636363, 4'h1, 4'h0};
    vt[2] = '{32'h00000000, 48'h081,           32'h6363636b, 4'h0, 4'h1};
    vt[3] = '{32'h00000000, 48'h008,           32'h63636363, 4'h1, 4'h0};
    vt[4] = '{32'h00000000, 48'h800000000000,  32'h63636363, 4'h8, 4'h0};
    vt[5] = '{32'h00000000, 48'h001100040200,  32'h63636363, 4'hf, 4'h0};
    vt[6] = '{32'h00000000, 48'h003,           32'h63636361, 4'h1, 4'h0};
    vt[7] = '{32'h53535353, 48'h0,             32'hedededed, 4'h0, 4'h0};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_flags", 64'({out_corr, out_uncorr}), 64'(0));
    check("rst_cnts", 64'({corr_cnt, uncorr_cnt, err_fatal}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vector table, one isolated beat each
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = vt[i].d; inj_mask = vt[i].inj;
      @(negedge clk);
      in_valid = 1'b0; inj_mask = '0;
      check("vec_lat1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("vec_valid", 64'(out_valid), 64'(1));
      check("vec_data", 64'(out_data), 64'(vt[i].ed));
      check("vec_corr", 64'(out_corr), 64'(vt[i].ec));
      check("vec_uncorr", 64'(out_uncorr), 64'(vt[i].eu));
    end
    @(negedge clk);
    check("vec_corr_cnt", 64'(corr_cnt), 64'(5));
    check("vec_uncorr_cnt", 64'(uncorr_cnt), 64'(1));
    check("vec_fatal", 64'(err_fatal), 64'(1));
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("clr_cnts", 64'({corr_cnt, uncorr_cnt}), 64'(0));
    check("clr_fatal", 64'(err_fatal), 64'(0));

    // Eight back-to-back beats with downstream stalled in cycles 3..5
    rx0 = received;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = 1'b1;
      in_data   = $urandom;
      inj_mask  = rand_inj();
      #4;
      if (cyc >= 3 && cyc <= 5) begin
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_s_in_ready", 64'(s_in_ready), 64'(0));
      end
      if (in_ready) idx++;
    end
    @(negedge clk);
    check("stall_sent", 64'(idx), 64'(8));
    drain();
    check("stall_received", 64'(received - rx0), 64'(8));

    // Saturation of the 2-bit counters, then clear racing an increment
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = $urandom; inj_mask = 48'h010;
      @(negedge clk);
    end
    in_valid = 1'b0; inj_mask = '0;
    repeat (3) @(negedge clk);
    check("sat_s_corr_cnt", 64'(s_corr_cnt), 64'(3));
    check("sat_corr_cnt", 64'(corr_cnt), 64'(5));
    in_valid = 1'b1; inj_mask = 48'h010;
    @(negedge clk);
    in_valid = 1'b0; inj_mask = '0;
    @(negedge clk);
    check("race_valid", 64'(out_valid), 64'(1));
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("race_corr_cnt", 64'(corr_cnt), 64'(0));
    check("race_s_corr_cnt", 64'(s_corr_cnt), 64'(0));

    // Randomized traffic with random back-pressure and occasional clears
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      inj_mask  = rand_inj();
      clr_stats = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    clr_stats = 1'b0;
    drain();

    // Reset with two beats in flight
    in_valid = 1'b1; in_data = 32'h01010101; inj_mask = 48'h081;
    @(negedge clk);
    in_data = 32'h02020202; inj_mask = 48'h010;
    @(negedge clk);
    in_valid = 1'b0; inj_mask = '0;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_cnts", 64'({corr_cnt, uncorr_cnt, err_fatal}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_data = 32'hff530100;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_lat1", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'(1));
    check("post_rst_data", 64'(out_data), 64'(32'h16ed7c63));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
